// File: rtl/mips_control.sv
// Main control decoder: maps instr[31:26] to registered datapath steering
// signals (register file, ALU, data memory, branch, jump).
module mips_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic [1:0] aluop,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrc,
  output logic       jump
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  logic               branch_eq_d, branch_eq_q;
  logic               branch_ne_d, branch_ne_q;
  logic [ALUOP_W-1:0] aluop_d,     aluop_q;
  logic               memread_d,   memread_q;
  logic               memwrite_d,  memwrite_q;
  logic               memtoreg_d,  memtoreg_q;
  logic               regdst_d,    regdst_q;
  logic               regwrite_d,  regwrite_q;
  logic               alusrc_d,    alusrc_q;
  logic               jump_d,      jump_q;

  // Opcode decode; unlisted or unknown (X/Z) opcodes fall to the all-zero NOP
  always_comb begin
    branch_eq_d = 1'b0;
    branch_ne_d = 1'b0;
    aluop_d     = ALUOP_ADD;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    regdst_d    = 1'b0;
    regwrite_d  = 1'b0;
    alusrc_d    = 1'b0;
    jump_d      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
        aluop_d    = ALUOP_FUNCT;
      end
      OP_LW: begin
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        aluop_d    = ALUOP_ADD;
      end
      OP_SW: begin
        alusrc_d   = 1'b1;
        memwrite_d = 1'b1;
        aluop_d    = ALUOP_ADD;
      end
      OP_BEQ: begin
        branch_eq_d = 1'b1;
        aluop_d     = ALUOP_SUB;
      end
      OP_BNE: begin
        branch_ne_d = 1'b1;
        aluop_d     = ALUOP_SUB;
      end
      OP_ADDI: begin
        alusrc_d   = 1'b1;
        regwrite_d = 1'b1;
        aluop_d    = ALUOP_ADD;
      end
      OP_J: begin
        jump_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output register aligning control with the stage after decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_eq_q <= 1'b0;
      branch_ne_q <= 1'b0;
      aluop_q     <= ALUOP_ADD;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      regdst_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      branch_eq_q <= branch_eq_d;
      branch_ne_q <= branch_ne_d;
      aluop_q     <= aluop_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      regdst_q    <= regdst_d;
      regwrite_q  <= regwrite_d;
      alusrc_q    <= alusrc_d;
      jump_q      <= jump_d;
    end
  end

  assign branch_eq = branch_eq_q;
  assign branch_ne = branch_ne_q;
  assign aluop     = aluop_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign memtoreg  = memtoreg_q;
  assign regdst    = regdst_q;
  assign regwrite  = regwrite_q;
  assign alusrc    = alusrc_q;
  assign jump      = jump_q;

endmodule

// File: tb/tb_mips_control.sv
// Bench for mips_control: directed and randomized opcodes checked against a
// table-driven reference of the decode rules.
module tb_mips_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       branch_eq, branch_ne, memread, memwrite, memtoreg;
  logic       regdst, regwrite, alusrc, jump;
  logic [1:0] aluop;

  int checks = 0;
  int errors = 0;

  // Expected outputs packed as a record of named fields
  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
    logic       jump;
  } ctrl_t;

  ctrl_t tbl [64];
  ctrl_t obs;
  ctrl_t zero_c;

  mips_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .aluop     (aluop),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump)
  );

  assign obs = '{branch_eq: branch_eq, branch_ne: branch_ne, aluop: aluop,
                 memread: memread, memwrite: memwrite, memtoreg: memtoreg,
                 regdst: regdst, regwrite: regwrite, alusrc: alusrc,
                 jump: jump};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the decode table from the written rules; everything else is NOP
  task automatic build_table();
    ctrl_t e;
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    e = '0; e.regdst = 1; e.regwrite = 1; e.aluop = 2'b10;                tbl[6'h00] = e;
    e = '0; e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.memread = 1;  tbl[6'h23] = e;
    e = '0; e.alusrc = 1; e.memwrite = 1;                                 tbl[6'h2B] = e;
    e = '0; e.branch_eq = 1; e.aluop = 2'b01;                             tbl[6'h04] = e;
    e = '0; e.branch_ne = 1; e.aluop = 2'b01;                             tbl[6'h05] = e;
    e = '0; e.alusrc = 1; e.regwrite = 1;                                 tbl[6'h08] = e;
    e = '0; e.jump = 1;                                                   tbl[6'h02] = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input ctrl_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    logic ok;
    ok = !(obs.memread && obs.memwrite) && !(obs.branch_eq && obs.branch_ne)
         && (obs.aluop != 2'b11) && (!obs.memtoreg || obs.memread)
         && (!obs.jump || (obs == ctrl_t'(11'b00000000001)));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s invariant observed=%b expected=1 (outputs %b)", tag, ok, obs);
    end
  endtask

  // Apply one opcode, clock it in, compare against the table
  task automatic apply(input logic [5:0] op, input string tag);
    opcode = op;
    tick();
    check($sformatf("%s_op%02h", tag, op), tbl[op]);
  endtask

  initial begin
    logic [5:0] sweep [7];
    logic [5:0] unk [3];
    logic [5:0] perm [64];
    logic [5:0] tmp;
    int j;

    zero_c = '0;
    build_table();
    sweep = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    unk   = '{6'h01, 6'h3F, 6'h0C};

    // Reset held with LW on the opcode bus
    rst_n  = 1'b0;
    opcode = 6'h23;
    #2;
    check("reset_async", zero_c);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", zero_c);
    end
    rst_n = 1'b1;
    #1;
    check("release_before_edge", zero_c);
    tick();
    check("release_first_edge", tbl[6'h23]);

    // Directed sweep of all defined opcodes
    foreach (sweep[i]) apply(sweep[i], "sweep");

    // Unknown opcodes decode to NOP
    foreach (unk[i]) apply(unk[i], "unknown");

    // Exhaustive opcode space in shuffled order
    for (int i = 0; i < 64; i++) perm[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      apply(perm[i], "exh");
      check_invariants("exh_inv");
    end

    // Random stream
    for (int i = 0; i < 100; i++) begin
      apply(6'($urandom), "rand");
      check_invariants("rand_inv");
    end

    // Async reset mid-stream while R-type is on the outputs
    apply(6'h00, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mid_drop", zero_c);
    tick();
    check("async_mid_hold", zero_c);
    #2;
    rst_n = 1'b1;
    tick();
    check("async_mid_release", tbl[6'h00]);

    // Opcode change between edges must not reach the outputs early
    apply(6'h00, "hold_pre");
    #2;
    opcode = 6'h2B;
    #2;
    check("hold_between_edges", tbl[6'h00]);
    tick();
    check("hold_after_edge", tbl[6'h2B]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
